// File: rtl/clock_edge_monitor.sv
// clock_edge_monitor
//   Watches a divided clock (i_clk_div) from the fast source clock domain,
//   produces per-edge strobes, measures every half period and tracks
//   whether the divided clock runs at the expected ratio (lock / loss).
//
// Ports
//   i_clk_mhz     : source clock, all logic on its rising edge
//   i_rstn_mhz    : asynchronous active-low reset
//   i_clk_div     : monitored divided clock (asynchronous)
//   i_rst_div     : active-high reset of the divided domain (asynchronous)
//   o_rise_ce     : one-cycle strobe per detected rising edge of i_clk_div
//   o_fall_ce     : one-cycle strobe per detected falling edge of i_clk_div
//   o_locked      : high while locked
//   o_lost        : high while lock has been lost
//   o_half_period : last measured half period, in i_clk_mhz cycles
//   o_loss_cnt    : number of lock losses, saturating at 255
module clock_edge_monitor #(
  parameter int unsigned par_clk_divisor = 1000,
  parameter int unsigned par_tolerance   = 2,
  parameter int unsigned par_lock_count  = 4
) (
  input  logic        i_clk_mhz,
  input  logic        i_rstn_mhz,
  input  logic        i_clk_div,
  input  logic        i_rst_div,
  output logic        o_rise_ce,
  output logic        o_fall_ce,
  output logic        o_locked,
  output logic        o_lost,
  output logic [15:0] o_half_period,
  output logic [7:0]  o_loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET,
    S_ACQUIRE,
    S_CHECK,
    S_LOCKED,
    S_LOST
  } state_t;

  localparam logic [15:0] LP_HALF = 16'(par_clk_divisor / 2);
  localparam logic [15:0] LP_TOL  = 16'(par_tolerance);
  localparam logic [15:0] LP_TMO  = 16'(par_clk_divisor / 2 + par_tolerance + 1);
  localparam logic [3:0]  LP_LOCK = 4'(par_lock_count);

  logic        r_div_s1, r_div_s2, r_div_s3;
  logic        r_rst_s1, r_rst_s2;
  logic        r_det_rise, r_det_fall;
  logic        r_rise_ce, r_fall_ce;
  logic        r_locked, r_lost;
  logic [3:0]  r_good;
  logic [15:0] r_cnt;
  logic [15:0] r_half;
  logic [7:0]  r_loss;
  state_t      r_state;

  logic        w_edge;
  logic [15:0] w_dev;
  logic        w_good;
  logic        w_timeout;
  logic        w_bad;
  state_t      w_state_nxt;
  logic [3:0]  w_good_nxt;
  logic        w_loss_inc;

  // Synchronizers, edge-detect register and registered edge detection.
  // The detection register aligns the FSM, counter and strobes so that all
  // of them react 3 source edges after i_clk_div is first sampled.
  always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
    if (!i_rstn_mhz) begin
      r_div_s1   <= 1'b0;
      r_div_s2   <= 1'b0;
      r_div_s3   <= 1'b0;
      r_rst_s1   <= 1'b1;
      r_rst_s2   <= 1'b1;
      r_det_rise <= 1'b0;
      r_det_fall <= 1'b0;
    end else begin
      r_div_s1   <= i_clk_div;
      r_div_s2   <= r_div_s1;
      r_div_s3   <= r_div_s2;
      r_rst_s1   <= i_rst_div;
      r_rst_s2   <= r_rst_s1;
      r_det_rise <= r_div_s2 & ~r_div_s3;
      r_det_fall <= ~r_div_s2 & r_div_s3;
    end
  end

  assign w_edge    = r_det_rise | r_det_fall;
  assign w_dev     = (r_cnt >= LP_HALF) ? (r_cnt - LP_HALF) : (LP_HALF - r_cnt);
  assign w_good    = (w_dev <= LP_TOL);
  // The counter runs past LP_TMO, so the timeout fires once per gap;
  // an edge in the same cycle wins.
  assign w_timeout = (r_cnt == LP_TMO) && !w_edge;
  assign w_bad     = (w_edge && !w_good) || w_timeout;

  always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
    if (!i_rstn_mhz) begin
      r_state <= S_RESET;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_RESET: begin
        w_good_nxt = '0;
        if (!r_rst_s2) w_state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (w_edge) begin
          w_good_nxt  = '0;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_edge && w_good) begin
          w_good_nxt = r_good + 4'd1;
          if (r_good + 4'd1 == LP_LOCK) w_state_nxt = S_LOCKED;
        end else if (w_bad) begin
          w_good_nxt = '0;
        end
      end
      S_LOCKED: begin
        if (w_bad) begin
          w_state_nxt = S_LOST;
          w_loss_inc  = 1'b1;
        end
      end
      S_LOST: begin
        if (w_edge) begin
          w_good_nxt  = '0;
          w_state_nxt = S_CHECK;
        end
      end
      default: begin
        w_state_nxt = S_RESET;
        w_good_nxt  = '0;
      end
    endcase
    // Divided-domain reset overrides everything, including a pending loss.
    if (r_rst_s2) begin
      w_state_nxt = S_RESET;
      w_good_nxt  = '0;
      w_loss_inc  = 1'b0;
    end
  end

  // Counter restarts at 1 on an edge so its value at the next edge equals
  // the strobe-to-strobe distance.
  always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
    if (!i_rstn_mhz) begin
      r_cnt     <= '0;
      r_half    <= '0;
      r_loss    <= '0;
      r_rise_ce <= 1'b0;
      r_fall_ce <= 1'b0;
      r_locked  <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      if (r_state == S_RESET)   r_cnt <= '0;
      else if (w_edge)          r_cnt <= 16'd1;
      else if (r_cnt != '1)     r_cnt <= r_cnt + 16'd1;

      if (w_edge && (r_state == S_CHECK || r_state == S_LOCKED || r_state == S_LOST))
        r_half <= r_cnt;

      if (w_loss_inc && (r_loss != '1)) r_loss <= r_loss + 8'd1;

      // Gating on the next state keeps strobes low whenever the FSM sits in S_RESET.
      r_rise_ce <= r_det_rise && (w_state_nxt != S_RESET);
      r_fall_ce <= r_det_fall && (w_state_nxt != S_RESET);
      r_locked  <= (w_state_nxt == S_LOCKED);
      r_lost    <= (w_state_nxt == S_LOST);
    end
  end

  assign o_rise_ce     = r_rise_ce;
  assign o_fall_ce     = r_fall_ce;
  assign o_locked      = r_locked;
  assign o_lost        = r_lost;
  assign o_half_period = r_half;
  assign o_loss_cnt    = r_loss;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Testbench for clock_edge_monitor (divisor 8, tolerance 1, lock count 4).
module tb_clock_edge_monitor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clk_div;
  logic        rst_div;
  logic        rise_ce, fall_ce, locked, lost;
  logic [15:0] half_period;
  logic [7:0]  loss_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic level = 1'b0;
  logic rstn_prev = 1'b0;

  typedef struct {
    logic        rise;
    int          cyc;
    logic [15:0] half;
    logic        lk;
    logic        ls;
  } strobe_t;

  typedef struct {
    int          cyc;
    string       name;
    logic        lk;
    logic        ls;
    logic [15:0] half;
    logic [7:0]  loss;
  } status_t;

  strobe_t sb[$];
  status_t ck[$];
  strobe_t e;
  status_t s;

  clock_edge_monitor #(
    .par_clk_divisor(8),
    .par_tolerance  (1),
    .par_lock_count (4)
  ) dut (
    .i_clk_mhz    (clk),
    .i_rstn_mhz   (rstn),
    .i_clk_div    (clk_div),
    .i_rst_div    (rst_div),
    .o_rise_ce    (rise_ce),
    .o_fall_ce    (fall_ce),
    .o_locked     (locked),
    .o_lost       (lost),
    .o_half_period(half_period),
    .o_loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops strobe and status expectations and compares.
  always begin
    @(negedge clk or negedge rstn);
    if (rstn_prev && !rstn) begin
      rstn_prev = rstn;
      #1;
      n_vec++;
      if (rise_ce || fall_ce || locked || lost || half_period != 16'd0 || loss_cnt != 8'd0) begin
        n_miss++;
        $display("FAIL async_reset: rise=%b fall=%b locked=%b lost=%b half=%0d loss=%0d, required all 0",
                 rise_ce, fall_ce, locked, lost, half_period, loss_cnt);
      end
    end else begin
      rstn_prev = rstn;
      if (rstn && (rise_ce || fall_ce)) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_strobe at cycle %0d: rise=%b fall=%b, required no strobe",
                   cyc, rise_ce, fall_ce);
        end else begin
          e = sb.pop_front();
          if (rise_ce != e.rise || fall_ce != !e.rise || cyc != e.cyc ||
              half_period != e.half || locked != e.lk || lost != e.ls) begin
            n_miss++;
            $display("FAIL strobe: got rise=%b fall=%b cycle=%0d half=%0d locked=%b lost=%b, required rise=%b fall=%b cycle=%0d half=%0d locked=%b lost=%b",
                     rise_ce, fall_ce, cyc, half_period, locked, lost,
                     e.rise, !e.rise, e.cyc, e.half, e.lk, e.ls);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_vec++;
        n_miss++;
        e = sb.pop_front();
        $display("FAIL strobe_missing: none by cycle %0d, required rise=%b at cycle %0d",
                 cyc, e.rise, e.cyc);
      end
      if (ck.size() > 0 && ck[0].cyc <= cyc) begin
        s = ck.pop_front();
        n_vec++;
        if (locked != s.lk || lost != s.ls || half_period != s.half || loss_cnt != s.loss) begin
          n_miss++;
          $display("FAIL status_%s at cycle %0d: locked=%b lost=%b half=%0d loss=%0d, required locked=%b lost=%b half=%0d loss=%0d",
                   s.name, cyc, locked, lost, half_period, loss_cnt, s.lk, s.ls, s.half, s.loss);
        end
      end
    end
  end

  // Wait gap cycles, toggle the divided clock and queue the expected strobe.
  task automatic tog(input int gap, input logic [15:0] half, input logic lk, input logic ls);
    strobe_t x;
    repeat (gap) @(negedge clk);
    level   = ~level;
    clk_div = level;
    x.rise = level;
    x.cyc  = cyc + 4;
    x.half = half;
    x.lk   = lk;
    x.ls   = ls;
    sb.push_back(x);
  endtask

  task automatic chk(input int dly, input string nm, input logic lk, input logic ls,
                     input logic [15:0] h, input logic [7:0] l);
    status_t x;
    x.cyc  = cyc + dly;
    x.name = nm;
    x.lk   = lk;
    x.ls   = ls;
    x.half = h;
    x.loss = l;
    ck.push_back(x);
  endtask

  initial begin
    rstn    = 1'b0;
    rst_div = 1'b1;
    clk_div = 1'b0;
    chk(1, "reset", 1'b0, 1'b0, 16'd0, 8'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk(3, "rst_div_held", 1'b0, 1'b0, 16'd0, 8'd0);
    repeat (4) @(negedge clk);
    rst_div = 1'b0;

    // Nominal: lock on the 5th edge counting the acquire edge.
    tog(6, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tog(4, 16'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tog(4, 16'd4, 1'b1, 1'b0);

    // Stall after lock: lost once 6 cycles pass without an edge, then relock.
    chk(9,  "stall_before", 1'b1, 1'b0, 16'd4, 8'd0);
    chk(10, "stall_lost",   1'b0, 1'b1, 16'd4, 8'd1);
    tog(12, 16'd12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tog(4, 16'd4, 1'b0, 1'b0);
    tog(4, 16'd4, 1'b1, 1'b0);

    // Wrong rate: half period 6 breaks lock and never relocks.
    tog(6, 16'd6, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tog(6, 16'd6, 1'b0, 1'b0);
    chk(5, "wrong_rate", 1'b0, 1'b0, 16'd6, 8'd2);

    // Jitter 3/5 within tolerance.
    tog(3, 16'd3, 1'b0, 1'b0);
    tog(5, 16'd5, 1'b0, 1'b0);
    tog(3, 16'd3, 1'b0, 1'b0);
    tog(5, 16'd5, 1'b1, 1'b0);
    tog(3, 16'd3, 1'b1, 1'b0);
    tog(5, 16'd5, 1'b1, 1'b0);

    // Divided-domain reset pulse while locked; toggles inside give no strobes.
    chk(7,  "rst_div_sync",   1'b1, 1'b0, 16'd5, 8'd2);
    chk(8,  "rst_div_unlock", 1'b0, 1'b0, 16'd5, 8'd2);
    chk(13, "rst_div_hold",   1'b0, 1'b0, 16'd5, 8'd2);
    repeat (5) @(negedge clk);
    rst_div = 1'b1;
    repeat (3) @(negedge clk);
    level = ~level; clk_div = level;
    repeat (3) @(negedge clk);
    level = ~level; clk_div = level;
    repeat (4) @(negedge clk);
    rst_div = 1'b0;
    tog(6, 16'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tog(4, 16'd4, 1'b0, 1'b0);
    tog(4, 16'd4, 1'b1, 1'b0);

    // Asynchronous source reset mid-lock, then a fresh lock sequence.
    repeat (5) @(negedge clk);
    #2;
    rstn    = 1'b0;
    level   = 1'b0;
    clk_div = 1'b0;
    chk(1, "rstn_held", 1'b0, 1'b0, 16'd0, 8'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tog(6, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tog(4, 16'd4, 1'b0, 1'b0);
    tog(4, 16'd4, 1'b1, 1'b0);
    chk(5, "relock_after_rstn", 1'b1, 1'b0, 16'd4, 8'd0);
    repeat (8) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
